fetch_stage: RTL and testbench

- Instruction fetch stage of the RV32I pipeline. Sits directly upstream of the opcode/funct3 control decoder.
- Owns the PC register. Issues word requests to instruction memory over a valid/ready handshake and buffers returned instructions in a small FIFO.
- Presents one instruction per cycle to decode with stall backpressure.
- Handles redirects from branch/jal/jalr resolution, including discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: widths, the canonical NOP, RV32I major opcodes
// and the fetch buffer entry layout.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a combinational head.
// Flush wins over push and pop in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues credit-limited imem requests,
// buffers responses and discards those made stale by a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3
);

  localparam int             CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] buf_count;
  logic [XLEN-1:0]  redirect_target;
  logic             req_valid, req_fire, resp_stale, resp_push, out_valid, buf_pop;
  fetch_entry_t     buf_head, push_entry;

  assign redirect_target = word_align(redirect_pc);

  always_comb begin
    // In-flight requests plus buffered entries never exceed DEPTH, so every response has a slot.
    req_valid  = !rst && !redirect_valid &&
                 (({1'b0, pending_q} + {1'b0, buf_count}) < DEPTH_W);
    req_fire   = req_valid && imem_req_ready;
    resp_stale = imem_resp_valid && (drop_cnt_q != '0);
    resp_push  = imem_resp_valid && !resp_stale && !redirect_valid;
    out_valid  = !rst && (buf_count != '0) && !redirect_valid;
    buf_pop    = out_valid && !stall;

    push_entry.pc    = resp_pc_q;
    push_entry.instr = imem_resp_data;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    pending_d  = pending_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_cnt_d = pending_q - CNT_W'(imem_resp_valid);
    end else begin
      if (req_fire)   fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_push)  resp_pc_d  = resp_pc_q + XLEN'(4);
      if (resp_stale) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pending_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign if_valid       = out_valid;
  assign if_instr       = out_valid ? buf_head.instr : NOP_INSTR;
  assign if_pc          = out_valid ? buf_head.pc : '0;
  assign opcode         = if_instr[6:0];
  assign funct3         = if_instr[14:12];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order imem model with adjustable latency,
// a per-cycle order monitor, hand sequences and a redirect vector table.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .opcode          (opcode),
    .funct3          (funct3)
  );

  always #5 clk = ~clk;

  // mem[0] = 0x00500093; other words differ in the upper bits, funct3 = addr[4:2].
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 10);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // In-order memory: a request accepted in cycle n responds in cycle n+lat.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always @(negedge clk) begin
    mreq_t r;
    imem_resp_valid = 1'b0;
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_at(r.addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + lat;
        mq.push_back(r);
      end
    end
    cyc++;
  end

  // Order monitor: request addresses and delivered PCs must follow the program path.
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_pc  = 32'h0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_req = 32'h0;
      exp_pc  = 32'h0;
      chk("mon_rst_req_valid", imem_req_valid, 0);
      chk("mon_rst_if_valid", if_valid, 0);
    end else if (redirect_valid) begin
      chk("mon_redir_req_valid", imem_req_valid, 0);
      chk("mon_redir_if_valid", if_valid, 0);
      exp_req = redirect_pc & 32'hFFFF_FFFC;
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("mon_req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (if_valid) begin
        chk("mon_if_pc", if_pc, exp_pc);
        chk("mon_if_instr", if_instr, instr_at(exp_pc));
        if (!stall) exp_pc = exp_pc + 32'd4;
      end else begin
        chk("mon_idle_instr", if_instr, 32'h0000_0013);
        chk("mon_idle_pc", if_pc, 0);
      end
    end
  end

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [2:0]  exp_f3;
  } rvec_t;

  rvec_t vecs[6];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input string name);
    int i;
    i = 0;
    while (!if_valid && i < 50) begin
      @(posedge clk);
      #3;
      i++;
    end
    if (!if_valid) chk(name, 0, 1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #2;
    chk("redir_cycle_req_valid", imem_req_valid, 0);
    chk("redir_cycle_if_valid", if_valid, 0);
  endtask

  initial begin
    bit found;

    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 3'd0};
    vecs[1] = '{32'h0000_1001, 32'h0000_1000, 3'd0};
    vecs[2] = '{32'h0000_00FE, 32'h0000_00FC, 3'd7};
    vecs[3] = '{32'h0000_0014, 32'h0000_0014, 3'd5};
    vecs[4] = '{32'h0000_0007, 32'h0000_0004, 3'd1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 3'd7};

    // Reset held for two edges.
    @(posedge clk);
    #3;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 0);
    @(posedge clk);
    #1;
    chk("rst2_req_valid", imem_req_valid, 0);
    chk("rst2_if_valid", if_valid, 0);
    rst   = 1'b0;
    stall = 1'b1;
    #2;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // Stall with two instructions buffered: no requests, head steady.
    repeat (3) next_cycle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #2;
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_if_valid", if_valid, 1);
      chk("stall_if_pc", if_pc, 32'h0);
      chk("stall_if_instr", if_instr, 32'h0050_0093);
      chk("stall_opcode", opcode, 7'b0010011);
      chk("stall_funct3", funct3, 3'b000);
    end
    $display("stall hold: head pc 0x%08h held for 4 cycles", if_pc);

    // Release stall and apply memory backpressure at the same time.
    next_cycle();
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #3;
      if (imem_req_valid) begin
        found = 1;
        break;
      end
    end
    chk("bp_req_seen", found, 1);
    chk("bp_req_addr", imem_req_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      chk("bp_hold_valid", imem_req_valid, 1);
      chk("bp_hold_addr", imem_req_addr, 32'h8);
    end
    next_cycle();
    imem_req_ready = 1'b1;
    $display("backpressure: request 0x%08h held, then released", imem_req_addr);
    repeat (10) next_cycle();

    // Redirect with two requests in flight.
    lat = 3;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (mq.size() == 2) begin
        found = 1;
        break;
      end
    end
    chk("inflight2_seen", found, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #2;
    chk("r2_req_valid", imem_req_valid, 0);
    chk("r2_if_valid", if_valid, 0);
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    chk("r2_next_addr", imem_req_addr, 32'h200);
    wait_if("r2_if_timeout");
    chk("r2_first_pc", if_pc, 32'h200);
    $display("redirect 0x203 with 2 in flight: first pc 0x%08h", if_pc);
    repeat (6) next_cycle();

    // Back-to-back redirects: the later target wins.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (mq.size() >= 1) begin
        found = 1;
        break;
      end
    end
    chk("b2b_inflight_seen", found, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    redirect_to(32'h500);
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    chk("b2b_next_addr", imem_req_addr, 32'h500);
    wait_if("b2b_if_timeout");
    chk("b2b_first_pc", if_pc, 32'h500);
    $display("back-to-back redirect 0x300,0x500: first pc 0x%08h", if_pc);
    repeat (6) next_cycle();

    // Redirect coinciding with a response arrival and a pop.
    lat = 1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      if (if_valid && mq.size() > 0 && mq[0].due <= cyc) begin
        found = 1;
        break;
      end
    end
    chk("coincide_seen", found, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    #2;
    chk("co_if_valid", if_valid, 0);
    next_cycle();
    redirect_valid = 1'b0;
    #2;
    chk("co_flushed", if_valid, 0);
    chk("co_next_addr", imem_req_addr, 32'h400);
    wait_if("co_if_timeout");
    chk("co_first_pc", if_pc, 32'h400);
    $display("redirect with resp+pop: first pc 0x%08h", if_pc);
    repeat (4) next_cycle();

    // Redirect target table.
    for (int v = 0; v < 6; v++) begin
      redirect_to(vecs[v].target);
      next_cycle();
      redirect_valid = 1'b0;
      #2;
      chk("tbl_next_addr", imem_req_addr, vecs[v].exp_addr);
      wait_if("tbl_if_timeout");
      chk("tbl_first_pc", if_pc, vecs[v].exp_addr);
      chk("tbl_funct3", funct3, vecs[v].exp_f3);
      chk("tbl_opcode", opcode, 7'b0010011);
      $display("vector %0d: target 0x%08h -> first pc 0x%08h funct3 %0d",
               v, vecs[v].target, if_pc, funct3);
      repeat (5) next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

endmodule
